// File: rtl/aukv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : aukv_fetch_queue
// Description : In-order instruction fetch unit with an outstanding-request tag
//               FIFO, a decode-side instruction queue and redirect/drop handling.
// Revision    : 1.0 - initial release
// ============================================================================
module aukv_fetch_queue #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic [31:0]              o_instr_addr,
    output logic                     o_instr_addr_valid,
    input  logic                     i_instr_addr_ready,
    input  logic [31:0]              i_instr_data,
    input  logic                     i_instr_data_valid,
    input  logic                     i_stall,
    input  logic                     i_redirect,
    input  logic [31:0]              i_redirect_addr,
    output logic [31:0]              o_instr,
    output logic [31:0]              o_pc,
    output logic                     o_instr_valid,
    output logic [$clog2(DEPTH):0]   o_queue_count
);

    localparam int QW = $clog2(DEPTH);
    localparam int CW = QW + 1;
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [31:0]   c_NOP       = 32'h0000_0033;
    localparam logic [TW-1:0] c_TAG_LAST  = TW'(MAX_OUTST - 1);
    localparam logic [CW-1:0] c_MAX_OUTST = CW'(MAX_OUTST);
    localparam logic [CW:0]   c_DEPTH     = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_last_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tag_wr;
    logic [TW-1:0] r_tag_rd;
    logic [QW-1:0] r_q_wr;
    logic [QW-1:0] r_q_rd;

    logic [31:0]   r_tag_mem [MAX_OUTST];
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];

    logic          w_req_valid;
    logic          w_accept;
    logic          w_resp_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW:0]   w_inflight;
    logic [CW-1:0] w_acc_inc;
    logic [CW-1:0] w_resp_dec;
    logic [CW-1:0] w_push_inc;
    logic [CW-1:0] w_pop_dec;
    logic [TW-1:0] w_tag_wr_nxt;
    logic [TW-1:0] w_tag_rd_nxt;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;

    // Requests in flight plus queued entries bound the queue, so it never overflows.
    assign w_inflight  = {1'b0, r_outst} + {1'b0, r_count};
    assign w_req_valid = ~i_rst & ~i_redirect & (r_outst < c_MAX_OUTST)
                       & (w_inflight < c_DEPTH) & (r_drop == '0);
    assign w_accept    = w_req_valid & i_instr_addr_ready;
    assign w_resp_ok   = i_instr_data_valid & (r_outst != '0);
    assign w_push      = w_resp_ok & ~i_redirect & (r_drop == '0);
    assign w_empty     = (r_count == '0);
    assign w_pop       = ~w_empty & ~i_stall & ~i_redirect;

    assign w_acc_inc   = {{(CW-1){1'b0}}, w_accept};
    assign w_resp_dec  = {{(CW-1){1'b0}}, w_resp_ok};
    assign w_push_inc  = {{(CW-1){1'b0}}, w_push};
    assign w_pop_dec   = {{(CW-1){1'b0}}, w_pop};

    assign w_tag_wr_nxt = (r_tag_wr == c_TAG_LAST) ? '0 : r_tag_wr + 1'b1;
    assign w_tag_rd_nxt = (r_tag_rd == c_TAG_LAST) ? '0 : r_tag_rd + 1'b1;

    assign w_head_pc    = r_q_pc[r_q_rd];
    assign w_head_instr = r_q_instr[r_q_rd];

    assign o_instr_addr       = r_fetch_pc;
    assign o_instr_addr_valid = w_req_valid;
    assign o_instr_valid      = w_pop;
    assign o_instr            = w_pop ? w_head_instr : c_NOP;
    assign o_pc               = w_empty ? r_last_pc : w_head_pc;
    assign o_queue_count      = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_VEC;
            r_last_pc  <= RESET_VEC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_q_wr     <= '0;
            r_q_rd     <= '0;
        end else if (i_redirect) begin
            // Whatever is still pending after this cycle's response must be discarded.
            r_fetch_pc <= i_redirect_addr;
            r_outst    <= r_outst - w_resp_dec;
            r_drop     <= r_outst - w_resp_dec;
            r_count    <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_q_wr     <= '0;
            r_q_rd     <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tag_wr   <= w_tag_wr_nxt;
            end
            if (w_resp_ok && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
            if (w_push) begin
                r_tag_rd <= w_tag_rd_nxt;
                r_q_wr   <= r_q_wr + 1'b1;
            end
            if (w_pop) begin
                r_q_rd    <= r_q_rd + 1'b1;
                r_last_pc <= w_head_pc;
            end
            r_outst <= r_outst + w_acc_inc - w_resp_dec;
            r_count <= r_count + w_push_inc - w_pop_dec;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_tag_mem[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_q_wr]    <= r_tag_mem[r_tag_rd];
            r_q_instr[r_q_wr] <= i_instr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aukv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_aukv_fetch_queue
// Description : Directed scoreboard bench for aukv_fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aukv_fetch_queue;

    localparam logic [31:0] c_RESET_VEC = 32'h8000_0000;
    localparam int          c_DEPTH     = 4;
    localparam int          c_MAX_OUTST = 2;
    localparam logic [31:0] c_NOP       = 32'h0000_0033;

    logic                     i_clk;
    logic                     i_rst;
    logic [31:0]              o_instr_addr;
    logic                     o_instr_addr_valid;
    logic                     i_instr_addr_ready;
    logic [31:0]              i_instr_data;
    logic                     i_instr_data_valid;
    logic                     i_stall;
    logic                     i_redirect;
    logic [31:0]              i_redirect_addr;
    logic [31:0]              o_instr;
    logic [31:0]              o_pc;
    logic                     o_instr_valid;
    logic [$clog2(c_DEPTH):0] o_queue_count;

    aukv_fetch_queue #(
        .RESET_VEC (c_RESET_VEC),
        .DEPTH     (c_DEPTH),
        .MAX_OUTST (c_MAX_OUTST)
    ) u_dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .o_instr_addr       (o_instr_addr),
        .o_instr_addr_valid (o_instr_addr_valid),
        .i_instr_addr_ready (i_instr_addr_ready),
        .i_instr_data       (i_instr_data),
        .i_instr_data_valid (i_instr_data_valid),
        .i_stall            (i_stall),
        .i_redirect         (i_redirect),
        .i_redirect_addr    (i_redirect_addr),
        .o_instr            (o_instr),
        .o_pc               (o_pc),
        .o_instr_valid      (o_instr_valid),
        .o_queue_count      (o_queue_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    bit          mem_hold = 1'b0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_stream(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic wait_acc(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_instr_addr_valid && i_instr_addr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(name, 32'd0, 32'd1);
    endtask

    // Memory model: in-order, one cycle after acceptance unless held.
    initial begin
        i_instr_data_valid = 1'b0;
        i_instr_data       = '0;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst) begin
                mem_q.delete();
                i_instr_data_valid = 1'b0;
            end else if (!mem_hold && mem_q.size() > 0) begin
                i_instr_data       = mem_word(mem_q.pop_front());
                i_instr_data_valid = 1'b1;
            end else begin
                i_instr_data_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_instr_addr_valid && i_instr_addr_ready)
                mem_q.push_back(o_instr_addr);
        end
    end

    // Monitor: every delivered instruction must be the next one expected.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", o_pc, e);
                    chk("mon_instr", o_instr, mem_word(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        i_rst              = 1'b1;
        i_instr_addr_ready = 1'b0;
        i_stall            = 1'b0;
        i_redirect         = 1'b0;
        i_redirect_addr    = '0;

        // Reset state
        repeat (2) step();
        @(negedge i_clk);
        chk("rst_addr_valid", {31'd0, o_instr_addr_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_instr", o_instr, c_NOP);
        chk("rst_pc", o_pc, c_RESET_VEC);
        chk("rst_count", 32'(o_queue_count), 32'd0);
        chk("rst_addr", o_instr_addr, c_RESET_VEC);

        // First fetch latency
        step();
        push_stream(c_RESET_VEC);
        i_rst              = 1'b0;
        i_instr_addr_ready = 1'b1;
        wait_acc("first_acc_timeout");
        chk("first_req_addr", o_instr_addr, c_RESET_VEC);
        @(negedge i_clk);
        chk("first_valid_early", {31'd0, o_instr_valid}, 32'd0);
        @(negedge i_clk);
        chk("first_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("first_pc", o_pc, c_RESET_VEC);
        repeat (6) step();

        // Stall saturation and drain
        i_stall = 1'b1;
        repeat (9) step();
        @(negedge i_clk);
        chk("stall_count", 32'(o_queue_count), 32'd4);
        chk("stall_addr_valid", {31'd0, o_instr_addr_valid}, 32'd0);
        chk("stall_instr", o_instr, c_NOP);
        chk("stall_instr_valid", {31'd0, o_instr_valid}, 32'd0);
        step();
        i_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("release_valid", {31'd0, o_instr_valid}, 32'd1);
        end

        // Redirect with two requests outstanding
        step();
        mem_hold = 1'b1;
        repeat (8) step();
        i_redirect      = 1'b1;
        i_redirect_addr = 32'h8000_0100;
        push_stream(32'h8000_0100);
        @(negedge i_clk);
        chk("redir_addr_valid", {31'd0, o_instr_addr_valid}, 32'd0);
        chk("redir_instr_valid", {31'd0, o_instr_valid}, 32'd0);
        step();
        i_redirect = 1'b0;
        mem_hold   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("drop_no_req", {31'd0, o_instr_addr_valid}, 32'd0);
        end
        wait_acc("redir_acc_timeout");
        chk("redir_req_addr", o_instr_addr, 32'h8000_0100);
        repeat (6) step();

        // Redirect coinciding with a response and a stall
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i_instr_data_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("find_resp_timeout", 32'd0, 32'd1);
        i_stall         = 1'b1;
        i_redirect      = 1'b1;
        i_redirect_addr = 32'h8000_0200;
        push_stream(32'h8000_0200);
        @(negedge i_clk);
        chk("coll_instr_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("coll_instr", o_instr, c_NOP);
        step();
        i_redirect = 1'b0;
        i_stall    = 1'b0;
        @(negedge i_clk);
        chk("coll_flushed_count", 32'(o_queue_count), 32'd0);
        repeat (8) step();

        // Fetch PC wrap
        i_redirect      = 1'b1;
        i_redirect_addr = 32'hFFFF_FFF8;
        push_stream(32'hFFFF_FFF8);
        step();
        i_redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_instr_addr_valid && i_instr_addr_ready && o_instr_addr == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("wrap_acc_timeout", 32'd0, 32'd1);
        wait_acc("wrap_next_timeout");
        chk("wrap_next_addr", o_instr_addr, 32'h0000_0000);
        repeat (4) step();

        // Asynchronous reset with a full queue
        i_stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            if (o_queue_count == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("fill_timeout", 32'd0, 32'd1);
        @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_count", 32'(o_queue_count), 32'd0);
        chk("arst_instr_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("arst_instr", o_instr, c_NOP);
        chk("arst_pc", o_pc, c_RESET_VEC);
        chk("arst_addr_valid", {31'd0, o_instr_addr_valid}, 32'd0);
        chk("arst_addr", o_instr_addr, c_RESET_VEC);
        repeat (2) step();
        push_stream(c_RESET_VEC);
        i_stall = 1'b0;
        i_rst   = 1'b0;
        wait_acc("post_rst_acc_timeout");
        chk("post_rst_addr", o_instr_addr, c_RESET_VEC);
        repeat (12) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
